// File: rtl/rvp_run_ctrl_if.sv
// rtl/rvp_run_ctrl_if.sv - pipeline observation bus (PC and write-back port) seen by the run controller
interface rvp_run_ctrl_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc_out;
   logic            wb_e;
   logic [4:0]      wb_a;
   logic [XLEN-1:0] wb_d;

   // pipeline side drives, controller side observes
   modport master (output pc_out, wb_e, wb_a, wb_d);
   modport slave  (input  pc_out, wb_e, wb_a, wb_d);
endinterface

// File: rtl/rvp_run_ctrl.sv
// rtl/rvp_run_ctrl.sv - run/termination controller (IDLE/RUN/DRAIN/DUMP/DONE), optional signature via RVP_RUN_CTRL_SIG_EN
module rvp_run_ctrl #(
   parameter int XLEN         = 32,
   parameter int PC_LIMIT     = 150,
   parameter int MAX_CYCLES   = 200,
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              halt_req,
   rvp_run_ctrl_if.slave     pipe,
   output logic              dump,
   output logic              done,
   output logic              busy,
   output logic [1:0]        cause,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [XLEN-1:0]   signature
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DUMP,
      S_DONE
   } state_t;

   // drain_cnt only has to reach DRAIN_CYCLES-1
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [XLEN-1:0]  PC_LIM   = XLEN'(PC_LIMIT);
   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [DW-1:0]    DRN_LAST = DW'(DRAIN_CYCLES - 1);

   state_t        state;
   logic [DW-1:0] drain_cnt;
   logic          wb_hit;
   logic          pc_hit;
   logic          tmo_hit;

   // a write-back counts only while the pipeline is still live and only for real registers
   assign wb_hit  = pipe.wb_e && (pipe.wb_a != 5'd0) && ((state == S_RUN) || (state == S_DRAIN));
   assign pc_hit  = (pipe.pc_out >= PC_LIM);
   assign tmo_hit = (cycle_cnt == CYC_LAST);

   // sequencing FSM with registered status outputs and saturating statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         dump       <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         cause      <= 2'd0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         drain_cnt  <= '0;
      end else begin
         dump <= 1'b0;
         if (wb_hit && (retire_cnt != '1)) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (cycle_cnt != '1) begin
                  cycle_cnt <= cycle_cnt + CNT_W'(1);
               end
               if (halt_req || pc_hit || tmo_hit) begin
                  state     <= S_DRAIN;
                  drain_cnt <= '0;
                  if (halt_req) begin
                     cause <= 2'd1;
                  end else if (pc_hit) begin
                     cause <= 2'd2;
                  end else begin
                     cause <= 2'd3;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRN_LAST) begin
                  state <= S_DUMP;
                  dump  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            S_DUMP: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RVP_RUN_CTRL_SIG_EN
   // rotate-and-xor checksum over the same write-backs that retire_cnt counts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         signature <= '0;
      end else if (wb_hit) begin
         signature <= {signature[XLEN-2:0], signature[XLEN-1]} ^ pipe.wb_d
                      ^ {{(XLEN-5){1'b0}}, pipe.wb_a};
      end
   end
`else
   logic sig_unused;
   assign sig_unused = ^pipe.wb_d;
   assign signature  = '0;
`endif

endmodule

// File: tb/tb_rvp_run_ctrl.sv
// tb/tb_rvp_run_ctrl.sv - randomized self-checking bench for rvp_run_ctrl against a trace-level model
module tb_rvp_run_ctrl;
   localparam int XLEN         = 32;
   localparam int PC_LIMIT     = 150;
   localparam int MAX_CYCLES   = 200;
   localparam int DRAIN_CYCLES = 4;
   localparam int CNT_W        = 32;
   localparam int NMAX         = 256;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             halt_req;
   logic             dump;
   logic             done;
   logic             busy;
   logic [1:0]       cause;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] retire_cnt;
   logic [XLEN-1:0]  signature;

   rvp_run_ctrl_if #(.XLEN(XLEN)) pipe ();

   rvp_run_ctrl #(
      .XLEN(XLEN), .PC_LIMIT(PC_LIMIT), .MAX_CYCLES(MAX_CYCLES),
      .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req), .pipe(pipe),
      .dump(dump), .done(done), .busy(busy), .cause(cause),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .signature(signature)
   );

   always #5 clk = ~clk;

   // per-RUN-edge stimulus trace
   logic            s_halt  [NMAX];
   logic [XLEN-1:0] s_pc    [NMAX];
   logic            s_we    [NMAX];
   logic [4:0]      s_wa    [NMAX];
   logic [XLEN-1:0] s_wd    [NMAX];
   logic            s_start [NMAX];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " dump"}, 64'(dump), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " cause"}, 64'(cause), 64'd0);
      chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'd0);
      chk({tag, " retire_cnt"}, 64'(retire_cnt), 64'd0);
      chk({tag, " signature"}, 64'(signature), 64'd0);
   endtask

   task automatic drive_idle();
      start = 1'b0; halt_req = 1'b0;
      pipe.pc_out = '0; pipe.wb_e = 1'b0; pipe.wb_a = '0; pipe.wb_d = '0;
   endtask

   // random write-back traffic and start noise, no exit causes
   task automatic fill_base();
      for (int i = 0; i < NMAX; i++) begin
         s_halt[i]  = 1'b0;
         s_pc[i]    = '0;
         s_we[i]    = 1'($urandom_range(0, 1));
         s_wa[i]    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         s_wd[i]    = $urandom;
         s_start[i] = 1'($urandom_range(0, 1));
      end
   endtask

   // first RUN edge at which an exit cause is seen, and which cause wins
   task automatic plan(output int e, output int c);
      e = MAX_CYCLES - 1;
      c = 3;
      for (int i = 0; i < MAX_CYCLES; i++) begin
         if (s_halt[i]) begin e = i; c = 1; break; end
         if (s_pc[i] >= PC_LIMIT) begin e = i; c = 2; break; end
      end
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      chk_zero({tag, " reset"});
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         pipe.wb_e = 1'b1; pipe.wb_a = 5'd3; pipe.wb_d = $urandom;
         @(negedge clk);
         chk({tag, " idle retire"}, 64'(retire_cnt), 64'd0);
         chk({tag, " idle busy"}, 64'(busy), 64'd0);
      end
      drive_idle();
   endtask

   // run one trace; abort_at >= 0 pulls reset asynchronously after that edge
   task automatic run_trace(input string tag, input int abort_at);
      int e, c, last;
      int ret;
      logic [XLEN-1:0] sig;
      logic eb, ed, edn;
      int ec, ecyc;
      plan(e, c);
      last = e + DRAIN_CYCLES + 3;
      ret = 0;
      sig = '0;
      do_reset(tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " start busy"}, 64'(busy), 64'd1);
      chk({tag, " start cycle_cnt"}, 64'(cycle_cnt), 64'd0);
      for (int j = 0; j <= last; j++) begin
         halt_req = s_halt[j]; pipe.pc_out = s_pc[j]; start = s_start[j];
         pipe.wb_e = s_we[j]; pipe.wb_a = s_wa[j]; pipe.wb_d = s_wd[j];
         @(negedge clk);
         if (j <= e + DRAIN_CYCLES && s_we[j] && s_wa[j] != 5'd0) begin
            ret++;
            sig = {sig[XLEN-2:0], sig[XLEN-1]} ^ s_wd[j] ^ XLEN'(s_wa[j]);
         end
         if (j < e) begin
            eb = 1; ed = 0; edn = 0; ec = 0; ecyc = j + 1;
         end else if (j < e + DRAIN_CYCLES) begin
            eb = 1; ed = 0; edn = 0; ec = c; ecyc = e + 1;
         end else if (j == e + DRAIN_CYCLES) begin
            eb = 0; ed = 1; edn = 0; ec = c; ecyc = e + 1;
         end else begin
            eb = 0; ed = 0; edn = 1; ec = c; ecyc = e + 1;
         end
         chk($sformatf("%s busy j=%0d", tag, j), 64'(busy), 64'(eb));
         chk($sformatf("%s dump j=%0d", tag, j), 64'(dump), 64'(ed));
         chk($sformatf("%s done j=%0d", tag, j), 64'(done), 64'(edn));
         chk($sformatf("%s cause j=%0d", tag, j), 64'(cause), 64'(ec));
         chk($sformatf("%s cycle_cnt j=%0d", tag, j), 64'(cycle_cnt), 64'(ecyc));
         chk($sformatf("%s retire_cnt j=%0d", tag, j), 64'(retire_cnt), 64'(ret));
`ifdef RVP_RUN_CTRL_SIG_EN
         chk($sformatf("%s signature j=%0d", tag, j), 64'(signature), 64'(sig));
`else
         chk($sformatf("%s signature j=%0d", tag, j), 64'(signature), 64'd0);
`endif
         if (j == abort_at) begin
            drive_idle();
            #2 reset_n = 1'b0;
            #1 chk_zero({tag, " async reset"});
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk({tag, " held dump"}, 64'(dump), 64'd0);
               chk({tag, " held busy"}, 64'(busy), 64'd0);
            end
            reset_n = 1'b1;
            @(negedge clk);
            chk({tag, " post idle busy"}, 64'(busy), 64'd0);
            chk({tag, " post idle dump"}, 64'(dump), 64'd0);
            chk({tag, " post idle done"}, 64'(done), 64'd0);
            break;
         end
      end
      drive_idle();
   endtask

   initial begin
      int e, c;
      reset_n = 1'b0;
      drive_idle();

      // pc stepping +4 per cycle: limit reached at pc=152
      fill_base();
      for (int i = 0; i < NMAX; i++) s_pc[i] = XLEN'(4 * i);
      plan(e, c);
      chk("pcstep plan cause", 64'(c), 64'd2);
      run_trace("pcstep", -1);

      // pc stuck at 0: timeout after MAX_CYCLES RUN cycles
      fill_base();
      run_trace("timeout", -1);
      chk("timeout final cycle_cnt", 64'(cycle_cnt), 64'(MAX_CYCLES));
      chk("timeout final cause", 64'(cause), 64'd3);

      // halt and pc limit on the same edge: halt wins
      fill_base();
      s_halt[17] = 1'b1;
      s_pc[17]   = XLEN'(160);
      run_trace("halt_pc", -1);
      chk("halt_pc final cause", 64'(cause), 64'd1);

      // random exits and traffic
      for (int r = 0; r < 4; r++) begin
         fill_base();
         for (int i = 0; i < NMAX; i++) begin
            s_halt[i] = ($urandom_range(0, 29) == 0);
            s_pc[i]   = XLEN'($urandom_range(0, 155));
         end
         run_trace($sformatf("rand%0d", r), -1);
      end

      // 10 write-backs (3 to x0) while live, 2 more after done
      fill_base();
      for (int i = 0; i < NMAX; i++) s_we[i] = 1'b0;
      s_halt[7] = 1'b1;
      s_wa[0] = 5'd1; s_wd[0] = 32'h5;
      s_wa[1] = 5'd2; s_wd[1] = 32'h3;
      s_wa[2] = 5'd0; s_wa[3] = 5'd3; s_wa[4] = 5'd0;
      s_wa[5] = 5'd4; s_wa[6] = 5'd5; s_wa[7] = 5'd0;
      s_wa[8] = 5'd6; s_wa[9] = 5'd7;
      for (int i = 0; i < 10; i++) s_we[i] = 1'b1;
      s_we[7 + DRAIN_CYCLES + 2] = 1'b1; s_wa[7 + DRAIN_CYCLES + 2] = 5'd9;
      s_we[7 + DRAIN_CYCLES + 3] = 1'b1; s_wa[7 + DRAIN_CYCLES + 3] = 5'd9;
      run_trace("retire", -1);
      chk("retire final count", 64'(retire_cnt), 64'd7);

      // asynchronous reset while draining
      fill_base();
      s_halt[30] = 1'b1;
      run_trace("abort", 32);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
